// File: rtl/i2si_bist_ctrl.sv
`default_nettype none
// ============================================================================
// i2si_bist_ctrl : sequencer, stream mux and saw-tooth checker for I2S-in BIST
// Revision 1.0
// ============================================================================
module i2si_bist_ctrl #(
   parameter int FRAME_W     = 16,
   parameter int ERR_W       = 8,
   parameter int ARM_TIMEOUT = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sck_transition,
   input  logic               rf_bist_en,
   input  logic [FRAME_W-1:0] rf_bist_frames,
   input  logic [11:0]        rf_bist_start_val,
   input  logic [7:0]         rf_bist_inc,
   input  logic [11:0]        rf_bist_up_limit,
   input  logic [31:0]        i2si_rx_data,
   input  logic               i2si_rx_xfc,
   input  logic [31:0]        i2si_bist_out_data,
   input  logic               i2si_bist_out_xfc,
   output logic               bist_gen_rst_n,
   output logic               bist_sck_transition,
   output logic [11:0]        bist_start_val,
   output logic [7:0]         bist_inc,
   output logic [11:0]        bist_up_limit,
   output logic [31:0]        i2si_out_data,
   output logic               i2si_out_xfc,
   output logic               bist_busy,
   output logic               bist_done,
   output logic               bist_pass,
   output logic               bist_timeout,
   output logic [ERR_W-1:0]   bist_err_cnt,
   output logic [FRAME_W-1:0] bist_frame_cnt
);

   localparam int                c_TO_W    = $clog2(ARM_TIMEOUT + 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ARM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [11:0]        start_q, start_d;
   logic [7:0]         inc_q, inc_d;
   logic [11:0]        lim_q, lim_d;
   logic [FRAME_W-1:0] frames_q, frames_d;
   logic [31:0]        exp_q, exp_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               pass_q, pass_d;
   logic               tmo_q, tmo_d;
   logic [c_TO_W-1:0]  arm_cnt_q, arm_cnt_d;
   logic               gen_rst_n_q;
   logic [31:0]        out_data_q;
   logic               out_xfc_q;

   logic               w_active;
   logic               w_mismatch;
   logic [ERR_W-1:0]   w_err_chk;
   logic [FRAME_W-1:0] w_frame_inc;
   logic [31:0]        w_exp_next;
   logic               w_sel_xfc;
   logic [31:0]        w_sel_data;

   assign w_active    = (state_q == S_ARM) || (state_q == S_RUN);
   assign w_mismatch  = (i2si_bist_out_data != exp_q);
   assign w_err_chk   = (w_mismatch && (err_q != {ERR_W{1'b1}})) ? err_q + ERR_W'(1) : err_q;
   assign w_frame_inc = frame_q + FRAME_W'(1);
   // The model free-runs from the latched config; it never follows received data.
   assign w_exp_next  = (exp_q >= {20'd0, lim_q}) ? {20'd0, start_q}
                                                  : exp_q + {24'd0, inc_q};

   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      inc_d     = inc_q;
      lim_d     = lim_q;
      frames_d  = frames_q;
      exp_d     = exp_q;
      err_d     = err_q;
      frame_d   = frame_q;
      pass_d    = pass_q;
      tmo_d     = tmo_q;
      arm_cnt_d = arm_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (rf_bist_en) begin
               start_d   = rf_bist_start_val;
               inc_d     = rf_bist_inc;
               lim_d     = rf_bist_up_limit;
               frames_d  = rf_bist_frames;
               exp_d     = {20'd0, rf_bist_start_val};
               err_d     = '0;
               frame_d   = '0;
               pass_d    = 1'b0;
               tmo_d     = 1'b0;
               arm_cnt_d = '0;
               if (rf_bist_frames == '0) begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
               end else begin
                  state_d = S_ARM;
               end
            end
         end
         S_ARM, S_RUN: begin
            // Abort takes priority over a word arriving in the same cycle.
            if (!rf_bist_en) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
            end else if (i2si_bist_out_xfc) begin
               err_d   = w_err_chk;
               frame_d = w_frame_inc;
               exp_d   = w_exp_next;
               if (w_frame_inc == frames_q) begin
                  state_d = S_DONE;
                  pass_d  = (w_err_chk == '0);
               end else begin
                  state_d = S_RUN;
               end
            end else if ((state_q == S_ARM) && sck_transition) begin
               if (arm_cnt_q == c_TO_LAST) begin
                  state_d = S_DONE;
                  tmo_d   = 1'b1;
                  pass_d  = 1'b0;
               end else begin
                  arm_cnt_d = arm_cnt_q + c_TO_W'(1);
               end
            end
         end
         S_DONE: begin
            if (!rf_bist_en) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         start_q   <= '0;
         inc_q     <= '0;
         lim_q     <= '0;
         frames_q  <= '0;
         exp_q     <= '0;
         err_q     <= '0;
         frame_q   <= '0;
         pass_q    <= 1'b0;
         tmo_q     <= 1'b0;
         arm_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         inc_q     <= inc_d;
         lim_q     <= lim_d;
         frames_q  <= frames_d;
         exp_q     <= exp_d;
         err_q     <= err_d;
         frame_q   <= frame_d;
         pass_q    <= pass_d;
         tmo_q     <= tmo_d;
         arm_cnt_q <= arm_cnt_d;
      end
   end

   // Source selection follows the registered state, so it only switches on a state change.
   assign w_sel_xfc  = w_active ? i2si_bist_out_xfc  : i2si_rx_xfc;
   assign w_sel_data = w_active ? i2si_bist_out_data : i2si_rx_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_rst_n_q <= 1'b0;
         out_data_q  <= '0;
         out_xfc_q   <= 1'b0;
      end else begin
         gen_rst_n_q <= w_active;
         out_xfc_q   <= w_sel_xfc;
         if (w_sel_xfc) begin
            out_data_q <= w_sel_data;
         end
      end
   end

   assign bist_gen_rst_n      = gen_rst_n_q;
   assign bist_sck_transition = sck_transition & gen_rst_n_q & w_active;
   assign bist_start_val      = start_q;
   assign bist_inc            = inc_q;
   assign bist_up_limit       = lim_q;
   assign i2si_out_data       = out_data_q;
   assign i2si_out_xfc        = out_xfc_q;
   assign bist_busy           = w_active;
   assign bist_done           = (state_q == S_DONE);
   assign bist_pass           = pass_q;
   assign bist_timeout        = tmo_q;
   assign bist_err_cnt        = err_q;
   assign bist_frame_cnt      = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_i2si_bist_ctrl.sv
`default_nettype none
// ============================================================================
// tb_i2si_bist_ctrl : directed + randomized self-checking bench for i2si_bist_ctrl
// Revision 1.0
// ============================================================================
module tb_i2si_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sck_transition;
   logic        rf_bist_en;
   logic [15:0] rf_bist_frames;
   logic [11:0] rf_bist_start_val;
   logic [7:0]  rf_bist_inc;
   logic [11:0] rf_bist_up_limit;
   logic [31:0] i2si_rx_data;
   logic        i2si_rx_xfc;
   logic [31:0] i2si_bist_out_data;
   logic        i2si_bist_out_xfc;
   logic        bist_gen_rst_n;
   logic        bist_sck_transition;
   logic [11:0] bist_start_val;
   logic [7:0]  bist_inc;
   logic [11:0] bist_up_limit;
   logic [31:0] i2si_out_data;
   logic        i2si_out_xfc;
   logic        bist_busy;
   logic        bist_done;
   logic        bist_pass;
   logic        bist_timeout;
   logic [7:0]  bist_err_cnt;
   logic [15:0] bist_frame_cnt;

   int vectors     = 0;
   int miscompares = 0;

   i2si_bist_ctrl #(.FRAME_W(16), .ERR_W(8), .ARM_TIMEOUT(128)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .sck_transition      (sck_transition),
      .rf_bist_en          (rf_bist_en),
      .rf_bist_frames      (rf_bist_frames),
      .rf_bist_start_val   (rf_bist_start_val),
      .rf_bist_inc         (rf_bist_inc),
      .rf_bist_up_limit    (rf_bist_up_limit),
      .i2si_rx_data        (i2si_rx_data),
      .i2si_rx_xfc         (i2si_rx_xfc),
      .i2si_bist_out_data  (i2si_bist_out_data),
      .i2si_bist_out_xfc   (i2si_bist_out_xfc),
      .bist_gen_rst_n      (bist_gen_rst_n),
      .bist_sck_transition (bist_sck_transition),
      .bist_start_val      (bist_start_val),
      .bist_inc            (bist_inc),
      .bist_up_limit       (bist_up_limit),
      .i2si_out_data       (i2si_out_data),
      .i2si_out_xfc        (i2si_out_xfc),
      .bist_busy           (bist_busy),
      .bist_done           (bist_done),
      .bist_pass           (bist_pass),
      .bist_timeout        (bist_timeout),
      .bist_err_cnt        (bist_err_cnt),
      .bist_frame_cnt      (bist_frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One full BIST run; the bench plays the generator and injects corrupted words.
   task automatic do_run(input int frames, input int start, input int inc, input int lim,
                         input int flip_idx, input int err_pct, input int gapmax,
                         input bit chg_cfg);
      int unsigned model[$];
      int unsigned e;
      int          nerr;
      int          gap;
      logic [31:0] w;
      rf_bist_frames    = 16'(frames);
      rf_bist_start_val = 12'(start);
      rf_bist_inc       = 8'(inc);
      rf_bist_up_limit  = 12'(lim);
      rf_bist_en        = 1'b1;
      cyc();
      chk("arm_busy", bist_busy, 1);
      chk("arm_genrst_lo", bist_gen_rst_n, 0);
      cyc();
      chk("arm_genrst_hi", bist_gen_rst_n, 1);
      chk("cfg_start", bist_start_val, 32'(start));
      chk("cfg_inc", bist_inc, 32'(inc));
      chk("cfg_lim", bist_up_limit, 32'(lim));
      if (chg_cfg) begin
         rf_bist_frames    = 16'($urandom_range(3, 1));
         rf_bist_start_val = 12'($urandom);
         rf_bist_inc       = 8'($urandom);
         rf_bist_up_limit  = 12'($urandom);
      end
      e = start;
      for (int k = 0; k < frames; k++) begin
         model.push_back(e);
         e = (e >= lim) ? start : e + inc;
      end
      nerr = 0;
      for (int k = 0; k < frames; k++) begin
         gap = $urandom_range(gapmax, 0);
         for (int g = 0; g < gap; g++) begin
            sck_transition = 1'($urandom_range(1, 0));
            #1;
            chk("sck_gate", bist_sck_transition, sck_transition);
            cyc();
         end
         sck_transition = 1'b0;
         w = model[k];
         if (k == flip_idx) w = w ^ 32'd1;
         else if ($urandom_range(99, 0) < err_pct) w = w ^ (32'd1 << $urandom_range(31, 0));
         if (w != model[k]) nerr++;
         i2si_bist_out_data = w;
         i2si_bist_out_xfc  = 1'b1;
         cyc();
         i2si_bist_out_xfc  = 1'b0;
         chk("out_xfc", i2si_out_xfc, 1);
         chk("out_data", i2si_out_data, w);
         chk("frame_cnt", bist_frame_cnt, 32'(k + 1));
         chk("err_cnt", bist_err_cnt, (nerr > 255) ? 255 : nerr);
         if (k == frames - 1) begin
            chk("done", bist_done, 1);
            chk("pass", bist_pass, (nerr == 0) ? 1 : 0);
            chk("timeout_clr", bist_timeout, 0);
            chk("busy_off", bist_busy, 0);
         end else begin
            chk("busy_run", bist_busy, 1);
         end
      end
      cyc();
      chk("done_hold", bist_done, 1);
      chk("genrst_done", bist_gen_rst_n, 0);
      rf_bist_en = 1'b0;
      cyc();
      chk("idle_done", bist_done, 0);
      chk("idle_pass_keep", bist_pass, (nerr == 0) ? 1 : 0);
      chk("idle_frame_keep", bist_frame_cnt, 32'(frames));
   endtask

   initial begin
      logic [31:0] r;
      rst_n              = 1'b0;
      sck_transition     = 1'b0;
      rf_bist_en         = 1'b0;
      rf_bist_frames     = '0;
      rf_bist_start_val  = '0;
      rf_bist_inc        = '0;
      rf_bist_up_limit   = '0;
      i2si_rx_data       = '0;
      i2si_rx_xfc        = 1'b0;
      i2si_bist_out_data = '0;
      i2si_bist_out_xfc  = 1'b0;
      cyc();
      cyc();
      chk("rst_genrst", bist_gen_rst_n, 0);
      chk("rst_busy", bist_busy, 0);
      chk("rst_done", bist_done, 0);
      chk("rst_pass", bist_pass, 0);
      chk("rst_err", bist_err_cnt, 0);
      chk("rst_frame", bist_frame_cnt, 0);
      chk("rst_out_xfc", i2si_out_xfc, 0);
      chk("rst_out_data", i2si_out_data, 0);
      chk("rst_start", bist_start_val, 0);
      rst_n = 1'b1;
      cyc();

      // Live path in IDLE: rx forwarded with one cycle latency, BIST dropped.
      r = $urandom;
      i2si_rx_data = r;
      i2si_rx_xfc  = 1'b1;
      cyc();
      i2si_rx_xfc  = 1'b0;
      chk("idle_rx_xfc", i2si_out_xfc, 1);
      chk("idle_rx_data", i2si_out_data, r);
      i2si_bist_out_xfc = 1'b1;
      cyc();
      i2si_bist_out_xfc = 1'b0;
      chk("idle_bist_drop", i2si_out_xfc, 0);

      do_run(5, 'h100, 'h10, 'h130, -1, 0, 2, 1'b0);
      do_run(5, 'h100, 'h10, 'h130, 2, 0, 1, 1'b0);

      // Zero frames: straight to DONE with pass, generator stays in reset.
      rf_bist_frames = '0;
      rf_bist_en     = 1'b1;
      cyc();
      chk("f0_done", bist_done, 1);
      chk("f0_pass", bist_pass, 1);
      chk("f0_genrst", bist_gen_rst_n, 0);
      cyc();
      chk("f0_genrst2", bist_gen_rst_n, 0);
      rf_bist_en = 1'b0;
      cyc();

      // ARM timeout after 128 sck pulses with no generator word.
      rf_bist_frames = 16'd3;
      rf_bist_en     = 1'b1;
      cyc();
      cyc();
      for (int p = 1; p <= 128; p++) begin
         sck_transition = 1'b1;
         if (p == 1) begin
            #1;
            chk("to_sck_pass", bist_sck_transition, 1);
         end
         cyc();
         sck_transition = 1'b0;
         if (p == 127) chk("to_not_yet", bist_busy, 1);
         if (p == 128) begin
            chk("to_done", bist_done, 1);
            chk("to_flag", bist_timeout, 1);
            chk("to_pass", bist_pass, 0);
         end
         cyc();
      end
      #1;
      chk("to_sck_gated", bist_sck_transition, 0);
      rf_bist_en = 1'b0;
      cyc();
      chk("to_keep", bist_timeout, 1);

      // Abort after two words; a word coinciding with the abort is not counted.
      rf_bist_frames    = 16'd10;
      rf_bist_start_val = 12'h200;
      rf_bist_inc       = 8'h04;
      rf_bist_up_limit  = 12'hFFF;
      rf_bist_en        = 1'b1;
      cyc();
      cyc();
      for (int k = 0; k < 2; k++) begin
         i2si_bist_out_data = 32'h200 + 32'(4 * k);
         i2si_bist_out_xfc  = 1'b1;
         cyc();
         i2si_bist_out_xfc  = 1'b0;
      end
      i2si_rx_data = $urandom;
      i2si_rx_xfc  = 1'b1;
      cyc();
      i2si_rx_xfc  = 1'b0;
      chk("run_rx_drop", i2si_out_xfc, 0);
      rf_bist_en         = 1'b0;
      i2si_bist_out_data = 32'h208;
      i2si_bist_out_xfc  = 1'b1;
      cyc();
      i2si_bist_out_xfc  = 1'b0;
      chk("ab_busy", bist_busy, 0);
      chk("ab_done", bist_done, 0);
      chk("ab_frame", bist_frame_cnt, 2);
      chk("ab_pass", bist_pass, 0);
      chk("ab_err", bist_err_cnt, 0);
      r = $urandom;
      i2si_rx_data = r;
      i2si_rx_xfc  = 1'b1;
      cyc();
      i2si_rx_xfc  = 1'b0;
      chk("ab_rx_xfc", i2si_out_xfc, 1);
      chk("ab_rx_data", i2si_out_data, r);

      // Saturating error counter.
      do_run(300, 'h010, 1, 'hFFF, -1, 100, 0, 1'b0);

      for (int n = 0; n < 8; n++) begin
         do_run($urandom_range(12, 1), $urandom_range(4095, 0), $urandom_range(255, 0),
                $urandom_range(4095, 0), -1, 20, 2, 1'b1);
      end

      // Asynchronous reset mid-run.
      rf_bist_frames    = 16'd8;
      rf_bist_start_val = 12'h055;
      rf_bist_inc       = 8'h01;
      rf_bist_up_limit  = 12'h0FF;
      rf_bist_en        = 1'b1;
      cyc();
      cyc();
      i2si_bist_out_data = 32'h0000_0BAD;
      i2si_bist_out_xfc  = 1'b1;
      cyc();
      i2si_bist_out_xfc  = 1'b0;
      #2;
      rst_n      = 1'b0;
      rf_bist_en = 1'b0;
      #1;
      chk("ar_busy", bist_busy, 0);
      chk("ar_genrst", bist_gen_rst_n, 0);
      chk("ar_frame", bist_frame_cnt, 0);
      chk("ar_err", bist_err_cnt, 0);
      chk("ar_out_xfc", i2si_out_xfc, 0);
      chk("ar_out_data", i2si_out_data, 0);
      chk("ar_start", bist_start_val, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2si_bist_ctrl.md
Name: i2si_bist_ctrl

Overview:
Sequencer and checker for the I2S-input BIST saw-tooth generator. It latches the BIST configuration and drives it to the generator, holds the generator in reset until a run is armed, and gates its serial-clock pulse. It steers either the live deserializer stream or the BIST stream onto the I2S-in output path. It checks every BIST word against an internal saw-tooth model and reports done, pass, error count and frame count to the register file.

Parameters:
FRAME_W, 16, width of frame-count register and target
ERR_W, 8, width of saturating mismatch counter
ARM_TIMEOUT, 128, sck_transition pulses allowed in ARM before first BIST xfc

Ports:
clk  in  1  master clock
rst_n  in  1  asynchronous active-low reset
sck_transition  in  1  serial-clock level-to-pulse strobe
rf_bist_en  in  1  run request; level-sensitive
rf_bist_frames  in  FRAME_W  words to check per run
rf_bist_start_val  in  12  saw-tooth start value
rf_bist_inc  in  8  saw-tooth increment
rf_bist_up_limit  in  12  saw-tooth upper limit
i2si_rx_data  in  32  live deserializer word
i2si_rx_xfc  in  1  live word valid (1-cycle pulse)
i2si_bist_out_data  in  32  generator word
i2si_bist_out_xfc  in  1  generator word valid (1-cycle pulse)
bist_gen_rst_n  out  1  registered active-low reset to generator
bist_sck_transition  out  1  gated sck_transition to generator
bist_start_val  out  12  latched config to generator
bist_inc  out  8  latched config to generator
bist_up_limit  out  12  latched config to generator
i2si_out_data  out  32  selected word (registered)
i2si_out_xfc  out  1  selected valid (registered)
bist_busy  out  1  high in ARM or RUN
bist_done  out  1  high in DONE
bist_pass  out  1  run result; valid when bist_done=1
bist_timeout  out  1  ARM timed out; valid when bist_done=1
bist_err_cnt  out  ERR_W  mismatches, saturating
bist_frame_cnt  out  FRAME_W  words checked this run

Behaviour:
- Reset values: all outputs 0, including bist_gen_rst_n=0. FSM resets to IDLE.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - bist_gen_rst_n=0; bist_sck_transition=0; mux selects rx.
  - On rf_bist_en=1:
    - Latch the three config values into bist_start_val, bist_inc and bist_up_limit.
    - Load the expected value exp = zero-extended start_val.
    - Clear err_cnt, frame_cnt, pass and timeout.
    - If rf_bist_frames==0: go to DONE with pass=1.
    - Otherwise: go to ARM.
- ARM:
  - bist_gen_rst_n=1 (registered, so it rises 1 cycle after ARM entry).
  - bist_sck_transition = sck_transition when bist_gen_rst_n=1.
  - Mux selects BIST.
  - Count sck_transition pulses. If the count reaches ARM_TIMEOUT with no BIST xfc: timeout=1, pass=0, go to DONE.
  - The first i2si_bist_out_xfc is checked as in RUN and moves the FSM to RUN.
- RUN, on each i2si_bist_out_xfc:
  - Compare i2si_bist_out_data with exp (all 32 bits). On mismatch, increment err_cnt, saturating at all-ones.
  - Increment frame_cnt.
  - Update exp = (exp >= up_limit) ? start_val : exp + inc. Use 32-bit unsigned arithmetic. The model never resyncs to the received data.
  - When frame_cnt reaches rf_bist_frames (value latched on entry): set pass = (err_cnt==0 including this word), go to DONE.
- DONE:
  - bist_gen_rst_n=0; bist_sck_transition=0; mux selects rx.
  - Status held until rf_bist_en=0, then go to IDLE. Status persists in IDLE until the next start.
- Abort: rf_bist_en=0 in ARM or RUN returns to IDLE immediately. pass=0, done not asserted, err_cnt and frame_cnt frozen.
- Output mux:
  - 1-cycle registered latency from the selected source to i2si_out_*.
  - The unselected source's xfc is dropped.
  - Selection changes only on a state change, so no partial word is merged.
- Config changes on rf_* during a run have no effect until the next IDLE→ARM transition.
- A BIST xfc arriving in the same cycle as rf_bist_en falling is ignored (abort wins).
- Async reset mid-run returns to reset values immediately.

Test Plan:
- start=0x100, inc=0x10, limit=0x130, frames=5, loopback generator model → i2si_out sequence 0x100,0x110,0x120,0x130,0x100; done=1, pass=1, err_cnt=0, frame_cnt=5.
- Same config, bench flips bit 0 of the 3rd BIST word → err_cnt=1, pass=0; 4th word still expected 0x130.
- frames=0 → DONE one cycle after enable, pass=1, bist_gen_rst_n never rises.
- No BIST xfc after enable, 128 sck_transition pulses → timeout=1, pass=0, done=1.
- Deassert rf_bist_en after 2 checked words → IDLE, frame_cnt=2, done=0; mux back to rx; next rx word appears on i2si_out one cycle after its xfc.
- 300 forced mismatches with ERR_W=8 → err_cnt saturates at 0xFF.
